sd_cmd_serial_card: RTL and testbench

Card-side serial engine for the SD CMD line, the opposite end of the host command serializer. Detects a host command start bit, shifts in the 48-bit frame, checks direction bit, end bit and CRC7, and hands the decoded index/argument to the card application over a REQ/ACK handshake. It then transmits the short (48-bit) or long (136-bit) response on the same CMD line after the N_CR turnaround. It sits between the card pad (`cmd_dat_i`/`cmd_out_o`/`cmd_oe_o`) and the card command decoder in the SD card model and loopback test harness.

---
 rtl/sd_cmd_serial_card.sv | 208 ++++++++++++++++++++
 tb/tb_sd_cmd_serial_card.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_cmd_serial_card.sv
// Card-side SD CMD line engine: receives a 48-bit host command, validates CRC7 and
// framing, hands it to the application, then returns an optional short/long response.
module sd_cmd_serial_card #(
  parameter int NCR = 2
) (
  input  logic         SD_CLK_IN,
  input  logic         RST_N_IN,
  input  logic         cmd_dat_i,
  output logic         cmd_out_o,
  output logic         cmd_oe_o,
  output logic [39:0]  CMD_OUT,
  output logic         REQ_OUT,
  input  logic         ACK_IN,
  input  logic [1:0]   RSP_SETTING_IN,
  input  logic [127:0] RSP_IN,
  output logic         BUSY_OUT,
  output logic [3:0]   STATUS
);
  // state      | meaning
  // S_IDLE     | line released, waiting for a start bit
  // S_RECV     | shifting in command bits 46..0
  // S_WAIT_ACK | REQ_OUT high, counting N_CR, waiting for ACK_IN
  // S_PREAMBLE | driving the single high preamble bit
  // S_SEND     | shifting out response bits, then releasing the line
  typedef enum logic [2:0] {S_IDLE, S_RECV, S_WAIT_ACK, S_PREAMBLE, S_SEND} state_t;

  localparam logic [6:0] NCR_L  = 7'(NCR);
  localparam logic [6:0] NCR_M1 = 7'(NCR - 1);

  state_t        state_q, state_d;
  logic [5:0]    bit_cnt_q, bit_cnt_d;
  logic [38:0]   rx_q, rx_d;
  logic [6:0]    crc_q, crc_d;
  logic          crc_err_q, crc_err_d;
  logic          frm_err_q, frm_err_d;
  logic [6:0]    ncr_cnt_q, ncr_cnt_d;
  logic          ack_q, ack_d;
  logic [1:0]    set_q, set_d;
  logic [135:0]  tx_q, tx_d;
  logic [7:0]    tx_idx_q, tx_idx_d;
  logic          out_q, out_d;
  logic          oe_q, oe_d;
  logic          req_q, req_d;
  logic          busy_q, busy_d;
  logic [39:0]   cmd_q, cmd_d;
  logic [3:0]    status_q, status_d;

  logic          frm_err_now, frame_ok, go_pre, tx_done, bit_tx, start_rx;
  logic [7:0]    tx_len;

  function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
    logic fb;
    fb = c[6] ^ b;
    return {c[5:0], 1'b0} ^ {3'b000, fb, 2'b00, fb};
  endfunction

  assign frm_err_now = frm_err_q | ~cmd_dat_i;
  assign frame_ok    = ~frm_err_now & ~crc_err_q;
  assign go_pre      = ack_q && (ncr_cnt_q >= NCR_M1);
  assign tx_len      = (set_q == 2'b11) ? 8'd136 : 8'd48;
  assign tx_done     = (tx_idx_q == tx_len);
  // a start bit seen while still waiting for ACK means the host gave up on us
  assign start_rx    = ~cmd_dat_i &
                       ((state_q == S_IDLE) | ((state_q == S_WAIT_ACK) & ~ack_q & ~ACK_IN));
  // long: header+payload from tx_q with forced end bit; short: payload, CRC/7F field, end bit
  assign bit_tx = (set_q == 2'b11)    ? ((tx_idx_q == 8'd135) | tx_q[135]) :
                  (tx_idx_q < 8'd40)  ? tx_q[135] :
                  (tx_idx_q < 8'd47)  ? ((set_q == 2'b10) | crc_q[6]) : 1'b1;

  always_ff @(posedge SD_CLK_IN or negedge RST_N_IN) begin
    if (!RST_N_IN) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      rx_q      <= '0;
      crc_q     <= '0;
      crc_err_q <= 1'b0;
      frm_err_q <= 1'b0;
      ncr_cnt_q <= '0;
      ack_q     <= 1'b0;
      set_q     <= '0;
      tx_q      <= '0;
      tx_idx_q  <= '0;
      out_q     <= 1'b1;
      oe_q      <= 1'b0;
      req_q     <= 1'b0;
      busy_q    <= 1'b0;
      cmd_q     <= '0;
      status_q  <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      rx_q      <= rx_d;
      crc_q     <= crc_d;
      crc_err_q <= crc_err_d;
      frm_err_q <= frm_err_d;
      ncr_cnt_q <= ncr_cnt_d;
      ack_q     <= ack_d;
      set_q     <= set_d;
      tx_q      <= tx_d;
      tx_idx_q  <= tx_idx_d;
      out_q     <= out_d;
      oe_q      <= oe_d;
      req_q     <= req_d;
      busy_q    <= busy_d;
      cmd_q     <= cmd_d;
      status_q  <= status_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (start_rx) state_d = S_RECV;
      S_RECV:     if (bit_cnt_q == 6'd47) state_d = frame_ok ? S_WAIT_ACK : S_IDLE;
      S_WAIT_ACK: begin
        if (start_rx)                                      state_d = S_RECV;
        else if (!ack_q && ACK_IN && RSP_SETTING_IN == 2'b00) state_d = S_IDLE;
        else if (go_pre)                                   state_d = S_PREAMBLE;
      end
      S_PREAMBLE: state_d = S_SEND;
      S_SEND:     if (tx_done) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bit_cnt_d = bit_cnt_q;
    rx_d      = rx_q;
    crc_d     = crc_q;
    crc_err_d = crc_err_q;
    frm_err_d = frm_err_q;
    ncr_cnt_d = ncr_cnt_q;
    ack_d     = ack_q;
    set_d     = set_q;
    tx_d      = tx_q;
    tx_idx_d  = tx_idx_q;
    out_d     = out_q;
    oe_d      = oe_q;
    req_d     = req_q;
    cmd_d     = cmd_q;
    status_d  = status_q;
    case (state_q)
      S_RECV: begin
        bit_cnt_d = bit_cnt_q + 6'd1;
        if (bit_cnt_q == 6'd1) frm_err_d = frm_err_q | ~cmd_dat_i;
        if (bit_cnt_q <= 6'd39) begin
          rx_d  = {rx_q[37:0], cmd_dat_i};
          crc_d = crc7_step(crc_q, cmd_dat_i);
        end else if (bit_cnt_q <= 6'd46) begin
          crc_err_d = crc_err_q | (cmd_dat_i != crc_q[6]);
          crc_d     = {crc_q[5:0], 1'b0};
        end else if (frame_ok) begin
          cmd_d     = {1'b0, rx_q};
          req_d     = 1'b1;
          ncr_cnt_d = '0;
          ack_d     = 1'b0;
        end else begin
          status_d[0] = crc_err_q;
          status_d[1] = frm_err_now;
        end
      end
      S_WAIT_ACK: begin
        if (ncr_cnt_q < NCR_L) ncr_cnt_d = ncr_cnt_q + 7'd1;
        if (!ack_q && ACK_IN) begin
          req_d = 1'b0;
          ack_d = 1'b1;
          set_d = RSP_SETTING_IN;
          tx_d  = (RSP_SETTING_IN == 2'b11) ? {8'h3F, RSP_IN} : {2'b00, RSP_IN[37:0], 96'd0};
        end else if (go_pre) begin
          oe_d     = 1'b1;
          out_d    = 1'b1;
          tx_idx_d = '0;
          crc_d    = '0;
        end
      end
      S_PREAMBLE, S_SEND: begin
        if (state_q == S_SEND && tx_done) begin
          oe_d        = 1'b0;
          out_d       = 1'b1;
          status_d[3] = 1'b1;
        end else begin
          out_d    = bit_tx;
          tx_idx_d = tx_idx_q + 8'd1;
          tx_d     = {tx_q[134:0], 1'b0};
          if (tx_idx_q < 8'd40)      crc_d = crc7_step(crc_q, tx_q[135]);
          else if (tx_idx_q < 8'd47) crc_d = {crc_q[5:0], 1'b0};
        end
      end
      default: ;
    endcase
    if (start_rx) begin
      bit_cnt_d = 6'd1;
      crc_d     = '0;
      crc_err_d = 1'b0;
      frm_err_d = 1'b0;
      req_d     = 1'b0;
      status_d  = {1'b0, (state_q == S_WAIT_ACK), 2'b00};
    end
    busy_d = (state_d != S_IDLE);
  end

  assign cmd_out_o = out_q;
  assign cmd_oe_o  = oe_q;
  assign CMD_OUT   = cmd_q;
  assign REQ_OUT   = req_q;
  assign BUSY_OUT  = busy_q;
  assign STATUS    = status_q;
endmodule

// File: tb/tb_sd_cmd_serial_card.sv
// Bench for sd_cmd_serial_card: drives host command frames, plays the application side
// and compares received commands and transmitted responses against a frame-level model.
module tb_sd_cmd_serial_card;
  localparam int NCR = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cmd_line = 1'b1;
  logic         ack = 1'b0;
  logic [1:0]   setting = 2'b00;
  logic [127:0] rsp = '0;
  logic         cmd_out_o, cmd_oe_o, REQ_OUT, BUSY_OUT;
  logic [39:0]  CMD_OUT;
  logic [3:0]   STATUS;
  int           errors = 0;
  int           checks = 0;

  always #5 clk = ~clk;

  sd_cmd_serial_card #(.NCR(NCR)) dut (
    .SD_CLK_IN(clk), .RST_N_IN(rst_n), .cmd_dat_i(cmd_line),
    .cmd_out_o(cmd_out_o), .cmd_oe_o(cmd_oe_o), .CMD_OUT(CMD_OUT),
    .REQ_OUT(REQ_OUT), .ACK_IN(ack), .RSP_SETTING_IN(setting), .RSP_IN(rsp),
    .BUSY_OUT(BUSY_OUT), .STATUS(STATUS)
  );

  // CRC7 as the remainder of msg(x)*x^7 divided by x^7+x^3+1
  function automatic logic [6:0] crc7_ref(input logic [39:0] msg);
    logic [46:0] v;
    v = {msg, 7'd0};
    for (int i = 46; i >= 7; i--)
      if (v[i]) v[i -: 8] = v[i -: 8] ^ 8'h89;
    return v[6:0];
  endfunction

  function automatic logic [47:0] make_cmd(input logic [5:0] idx, input logic [31:0] arg);
    logic [39:0] msg;
    msg = {2'b01, idx, arg};
    return {msg, crc7_ref(msg), 1'b1};
  endfunction

  // Returns on the falling edge just after the edge that samples the end bit.
  task automatic send_frame(input logic [47:0] f);
    for (int i = 47; i >= 0; i--) begin
      @(negedge clk);
      cmd_line = f[i];
    end
    @(negedge clk);
    cmd_line = 1'b1;
  endtask

  // ack_n falling edges after send_frame returns, pulse ACK; then watch the line.
  task automatic run_ack(input int ack_n, input logic [1:0] set, input logic [127:0] rv,
                         input logic [3:0] st_base, input string nm);
    logic [135:0] exp_bits, got;
    logic [39:0]  msg;
    logic [3:0]   exp_st;
    logic         pre_ok;
    int           exp_first, len, first_n, hi_cnt, k;
    got = '0; pre_ok = 1'b0; first_n = -1; hi_cnt = 0; k = 0;
    if (set == 2'b11) begin
      len = 136;
      exp_bits = {8'h3F, rv[127:1], 1'b1};
    end else begin
      len = 48;
      msg = {2'b00, rv[37:0]};
      exp_bits = {msg, (set == 2'b10) ? 7'h7F : crc7_ref(msg), 1'b1, 88'd0};
    end
    exp_first = (set == 2'b00) ? -1 : ((ack_n + 2 > NCR) ? ack_n + 2 : NCR);
    for (int n = 0; n < ack_n + NCR + 150; n++) begin
      if (n > 0) @(negedge clk);
      if (cmd_oe_o === 1'b1) begin
        hi_cnt++;
        if (first_n < 0) begin
          first_n = n;
          pre_ok = (cmd_out_o === 1'b1);
        end else if (k < 136) begin
          got[135 - k] = cmd_out_o;
          k++;
        end
      end
      if (n == ack_n) begin
        checks++;
        if (REQ_OUT !== 1'b1) begin
          errors++; $display("FAIL %s req_before_ack: got %b want 1", nm, REQ_OUT);
        end
        ack = 1'b1; setting = set; rsp = rv;
      end else begin
        ack = 1'b0;
      end
    end
    checks++;
    if (first_n != exp_first) begin
      errors++; $display("FAIL %s preamble_cycle: got %0d want %0d", nm, first_n, exp_first);
    end
    if (set != 2'b00) begin
      checks++;
      if (!pre_ok) begin
        errors++; $display("FAIL %s preamble_level: got 0 want 1", nm);
      end
      checks++;
      if (got !== exp_bits) begin
        errors++; $display("FAIL %s rsp_bits: got %h want %h", nm, got, exp_bits);
      end
      checks++;
      if (hi_cnt != len + 1) begin
        errors++; $display("FAIL %s oe_cycles: got %0d want %0d", nm, hi_cnt, len + 1);
      end
    end
    exp_st = st_base | ((set != 2'b00) ? 4'b1000 : 4'b0000);
    checks++;
    if (STATUS !== exp_st) begin
      errors++; $display("FAIL %s status_end: got %b want %b", nm, STATUS, exp_st);
    end
    checks++;
    if (REQ_OUT !== 1'b0 || BUSY_OUT !== 1'b0) begin
      errors++; $display("FAIL %s idle_end: got req=%b busy=%b want 0 0", nm, REQ_OUT, BUSY_OUT);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cmd_line = 1'b1; ack = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (cmd_oe_o !== 1'b0) begin errors++; $display("FAIL rst_oe: got %b want 0", cmd_oe_o); end
    checks++; if (cmd_out_o !== 1'b1) begin errors++; $display("FAIL rst_out: got %b want 1", cmd_out_o); end
    checks++; if (REQ_OUT !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", REQ_OUT); end
    checks++; if (CMD_OUT !== 40'd0) begin errors++; $display("FAIL rst_cmd: got %h want 0", CMD_OUT); end
    checks++; if (STATUS !== 4'd0) begin errors++; $display("FAIL rst_status: got %b want 0", STATUS); end
    checks++; if (BUSY_OUT !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", BUSY_OUT); end
    rst_n = 1'b1;
    @(negedge clk);
    ack = 1'b1; setting = 2'b01;
    @(negedge clk);
    ack = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (cmd_oe_o !== 1'b0 || BUSY_OUT !== 1'b0) begin
      errors++; $display("FAIL stray_ack: got oe=%b busy=%b want 0 0", cmd_oe_o, BUSY_OUT);
    end
  endtask

  task automatic test_cmd0();
    send_frame(48'h40_0000_0000_95);
    checks++; if (REQ_OUT !== 1'b1) begin errors++; $display("FAIL cmd0_req: got %b want 1", REQ_OUT); end
    checks++; if (CMD_OUT !== 40'h40_0000_0000) begin errors++; $display("FAIL cmd0_cmd: got %h want 4000000000", CMD_OUT); end
    checks++; if (BUSY_OUT !== 1'b1) begin errors++; $display("FAIL cmd0_busy: got %b want 1", BUSY_OUT); end
    run_ack(0, 2'b00, '0, 4'b0000, "cmd0");
  endtask

  task automatic test_short_rsp();
    send_frame(48'h48_0000_01AA_87);
    checks++; if (CMD_OUT !== 40'h48_0000_01AA) begin errors++; $display("FAIL cmd8_cmd: got %h want 48000001aa", CMD_OUT); end
    run_ack(0, 2'b01, {88'd0, 40'h08_0000_01AA}, 4'b0000, "cmd8");
  endtask

  task automatic test_crc_error();
    logic [39:0] msg;
    send_frame(48'h48_0000_01AA_85);
    checks++;
    if (STATUS !== 4'b0001 || REQ_OUT !== 1'b0 || BUSY_OUT !== 1'b0) begin
      errors++; $display("FAIL crc_err: got st=%b req=%b busy=%b want 0001 0 0", STATUS, REQ_OUT, BUSY_OUT);
    end
    ack = 1'b1; setting = 2'b01;
    @(negedge clk);
    ack = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (cmd_oe_o !== 1'b0 || BUSY_OUT !== 1'b0) begin
      errors++; $display("FAIL crc_err_ack: got oe=%b busy=%b want 0 0", cmd_oe_o, BUSY_OUT);
    end
    send_frame(48'h48_0000_01AA_86);
    checks++;
    if (STATUS !== 4'b0010 || REQ_OUT !== 1'b0) begin
      errors++; $display("FAIL end_bit_err: got st=%b req=%b want 0010 0", STATUS, REQ_OUT);
    end
    repeat (2) @(negedge clk);
    msg = {2'b00, 6'd8, 32'h0000_01AA};
    send_frame({msg, crc7_ref(msg), 1'b1});
    checks++;
    if (STATUS !== 4'b0010 || REQ_OUT !== 1'b0) begin
      errors++; $display("FAIL dir_bit_err: got st=%b req=%b want 0010 0", STATUS, REQ_OUT);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_r3();
    logic [47:0] f;
    f = make_cmd(6'd41, $urandom);
    send_frame(f);
    checks++; if (CMD_OUT !== f[47:8]) begin errors++; $display("FAIL r3_cmd: got %h want %h", CMD_OUT, f[47:8]); end
    run_ack(19, 2'b10, {88'd0, 40'h3F_00FF_8000}, 4'b0000, "r3");
  endtask

  task automatic test_long();
    logic [127:0] rv;
    rv = {$urandom, $urandom, $urandom, $urandom};
    send_frame(make_cmd(6'd2, 32'd0));
    run_ack(int'($urandom_range(0, 5)), 2'b11, rv, 4'b0000, "r2");
  endtask

  task automatic test_abandon();
    logic [47:0] fa, fb;
    fa = make_cmd(6'd17, $urandom);
    fb = make_cmd(6'd18, $urandom);
    send_frame(fa);
    repeat (3) @(negedge clk);
    for (int i = 47; i >= 0; i--) begin
      @(negedge clk);
      if (i == 46) begin
        checks++;
        if (REQ_OUT !== 1'b0 || STATUS !== 4'b0100) begin
          errors++; $display("FAIL abandon_drop: got req=%b st=%b want 0 0100", REQ_OUT, STATUS);
        end
      end
      cmd_line = fb[i];
    end
    @(negedge clk);
    cmd_line = 1'b1;
    checks++;
    if (REQ_OUT !== 1'b1 || CMD_OUT !== fb[47:8]) begin
      errors++; $display("FAIL abandon_second: got req=%b cmd=%h want 1 %h", REQ_OUT, CMD_OUT, fb[47:8]);
    end
    run_ack(int'($urandom_range(0, 6)), 2'($urandom_range(0, 3)),
            {$urandom, $urandom, $urandom, $urandom}, 4'b0100, "abandon");
  endtask

  task automatic test_back_to_back();
    logic [47:0] f;
    for (int it = 0; it < 8; it++) begin
      f = make_cmd(6'($urandom), $urandom);
      send_frame(f);
      checks++;
      if (REQ_OUT !== 1'b1 || CMD_OUT !== f[47:8]) begin
        errors++; $display("FAIL rand%0d_cmd: got req=%b cmd=%h want 1 %h", it, REQ_OUT, CMD_OUT, f[47:8]);
      end
      run_ack(int'($urandom_range(0, 12)), 2'($urandom_range(0, 3)),
              {$urandom, $urandom, $urandom, $urandom}, 4'b0000, "rand");
    end
  endtask

  task automatic test_reset_mid_send();
    logic [47:0] f;
    send_frame(make_cmd(6'd9, 32'h1234_0000));
    ack = 1'b1; setting = 2'b11; rsp = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    ack = 1'b0;
    for (int n = 0; n < 20 && cmd_oe_o !== 1'b1; n++) @(negedge clk);
    checks++;
    if (cmd_oe_o !== 1'b1) begin errors++; $display("FAIL mid_send_start: got oe=%b want 1", cmd_oe_o); end
    repeat (30) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (cmd_oe_o !== 1'b0 || cmd_out_o !== 1'b1 || BUSY_OUT !== 1'b0) begin
      errors++; $display("FAIL async_release: got oe=%b out=%b busy=%b want 0 1 0", cmd_oe_o, cmd_out_o, BUSY_OUT);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    f = make_cmd(6'd55, $urandom);
    send_frame(f);
    checks++;
    if (REQ_OUT !== 1'b1 || CMD_OUT !== f[47:8]) begin
      errors++; $display("FAIL post_reset_cmd: got req=%b cmd=%h want 1 %h", REQ_OUT, CMD_OUT, f[47:8]);
    end
    run_ack(1, 2'b01, {$urandom, $urandom, $urandom, $urandom}, 4'b0000, "post_reset");
  endtask

  initial begin
    test_reset();
    test_cmd0();
    test_short_rsp();
    test_crc_error();
    test_r3();
    test_long();
    test_abandon();
    test_back_to_back();
    test_reset_mid_send();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
